// File: rtl/hov_io_pkg.sv
// Shared constants for the Hovalaag host<->CPU stream buffer: host address map,
// status register layout and control-write bit positions.
package hov_io_pkg;

    localparam logic [3:0] ADDR_IN_BASE  = 4'd0;
    localparam logic [3:0] ADDR_OUT_BASE = 4'd8;
    localparam logic [3:0] ADDR_STATUS   = 4'd15;

    localparam int ST_OVF    = 0;
    localparam int ST_UDF    = 1;
    localparam int ST_CLKEN  = 2;
    localparam int ST_INFULL = 3;
    localparam int ST_OUT_NE = 4;

    localparam int CTRL_CLEAR = 0;
    localparam int CTRL_FLUSH = 1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/hov_sync_fifo.sv
// Single-clock FIFO with flush. Push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle; pop on empty is ignored.
module hov_sync_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hov_stream_io.sv
// Host<->CPU stream buffer: chunked host writes into per-channel input FIFOs,
// chunked host reads from output FIFOs, and the core step enable.
module hov_stream_io
    import hov_io_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int BUS_W   = 6,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [3:0]                            i_host_addr,
    input  logic                                  i_host_wr,
    input  logic                                  i_host_rd,
    input  logic [BUS_W-1:0]                      i_host_wdata,
    output logic [7:0]                            o_host_rdata,
    output logic [NUM_IN*DATA_W-1:0]              o_cpu_in_data,
    input  logic [NUM_IN-1:0]                     i_cpu_in_adv,
    input  logic [DATA_W-1:0]                     i_cpu_out_data,
    input  logic                                  i_cpu_out_valid,
    input  logic [$clog2(NUM_OUT>1?NUM_OUT:2)-1:0] i_cpu_out_sel,
    output logic                                  o_cpu_clk_en
);
    localparam int WR_CHUNKS = ceil_div(DATA_W, BUS_W);
    localparam int RD_CHUNKS = ceil_div(DATA_W, 8);
    localparam int WC_W      = (WR_CHUNKS > 1) ? $clog2(WR_CHUNKS) : 1;
    localparam int RC_W      = (RD_CHUNKS > 1) ? $clog2(RD_CHUNKS) : 1;
    localparam int RD_W      = RD_CHUNKS * 8;
    localparam int SEL_W     = $clog2(NUM_OUT > 1 ? NUM_OUT : 2);

    logic [NUM_IN-1:0]              w_in_push;
    logic [NUM_IN-1:0]              w_in_pop;
    logic [NUM_IN-1:0]              w_in_full;
    logic [NUM_IN-1:0]              w_in_empty;
    logic [NUM_IN-1:0]              w_ovf_set;
    logic [NUM_IN-1:0][DATA_W-1:0]  w_in_word;
    logic [NUM_IN-1:0][DATA_W-1:0]  w_in_head;
    logic [NUM_OUT-1:0]             w_out_push;
    logic [NUM_OUT-1:0]             w_out_pop;
    logic [NUM_OUT-1:0]             w_out_full;
    logic [NUM_OUT-1:0]             w_out_empty;
    logic [NUM_OUT-1:0]             w_udf_set;
    logic [NUM_OUT-1:0][DATA_W-1:0] w_out_head;
    logic [NUM_OUT-1:0][7:0]        w_rdata;
    logic [7:0]                     w_status;
    logic                           r_ovf;
    logic                           r_udf;
    logic                           w_ctrl_wr;
    logic                           w_clear;
    logic                           w_flush;
    logic                           w_clk_en;

    assign w_ctrl_wr    = i_host_wr && (i_host_addr == ADDR_STATUS);
    assign w_clear      = w_ctrl_wr && i_host_wdata[CTRL_CLEAR];
    assign w_flush      = w_ctrl_wr && i_host_wdata[CTRL_FLUSH];
    assign w_clk_en     = (&(~w_in_empty)) && (&(~w_out_full));
    assign o_cpu_clk_en = w_clk_en;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        logic [WC_W-1:0]            r_wr_cnt;
        logic [WR_CHUNKS*BUS_W-1:0] r_asm;
        logic [WR_CHUNKS*BUS_W-1:0] w_asm;
        logic                       w_sel;
        logic                       w_last;

        assign w_sel  = i_host_wr && (i_host_addr == 4'(ADDR_IN_BASE + k));
        assign w_last = (r_wr_cnt == WC_W'(WR_CHUNKS - 1));

        // Final chunk is merged combinationally so the word pushes in the same cycle.
        always_comb begin
            w_asm = r_asm;
            w_asm[r_wr_cnt*BUS_W +: BUS_W] = i_host_wdata;
        end

        assign w_in_push[k] = w_sel && w_last;
        assign w_in_word[k] = w_asm[DATA_W-1:0];
        assign w_in_pop[k]  = w_clk_en && i_cpu_in_adv[k];
        assign w_ovf_set[k] = w_in_push[k] && w_in_full[k] && !w_in_pop[k];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wr_cnt <= '0;
                r_asm    <= '0;
            end else if (w_clear) begin
                r_wr_cnt <= '0;
            end else if (w_sel) begin
                r_asm    <= w_asm;
                r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
            end
        end

        hov_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .i_push  (w_in_push[k]),
            .i_pop   (w_in_pop[k]),
            .i_flush (w_flush),
            .i_wdata (w_in_word[k]),
            .o_head  (w_in_head[k]),
            .o_full  (w_in_full[k]),
            .o_empty (w_in_empty[k])
        );

        assign o_cpu_in_data[k*DATA_W +: DATA_W] = w_in_head[k];
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        logic [RC_W-1:0] r_rd_cnt;
        logic [RD_W-1:0] w_head_pad;
        logic            w_sel;
        logic            w_last;
        logic            w_rd_ok;

        assign w_sel      = (i_host_addr == 4'(ADDR_OUT_BASE + j));
        assign w_last     = (r_rd_cnt == RC_W'(RD_CHUNKS - 1));
        assign w_rd_ok    = i_host_rd && w_sel && !w_out_empty[j];
        assign w_out_push[j] = w_clk_en && i_cpu_out_valid && (i_cpu_out_sel == SEL_W'(j));
        assign w_out_pop[j]  = w_rd_ok && w_last;
        assign w_udf_set[j]  = i_host_rd && w_sel && w_out_empty[j];
        assign w_head_pad    = RD_W'(w_out_head[j]);
        assign w_rdata[j]    = w_out_empty[j] ? 8'h00 : w_head_pad[r_rd_cnt*8 +: 8];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_rd_cnt <= '0;
            else if (w_clear)
                r_rd_cnt <= '0;
            else if (w_rd_ok)
                r_rd_cnt <= w_last ? '0 : r_rd_cnt + 1'b1;
        end

        hov_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .i_push  (w_out_push[j]),
            .i_pop   (w_out_pop[j]),
            .i_flush (w_flush),
            .i_wdata (i_cpu_out_data),
            .o_head  (w_out_head[j]),
            .o_full  (w_out_full[j]),
            .o_empty (w_out_empty[j])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (w_clear) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (|w_ovf_set) r_ovf <= 1'b1;
            if (|w_udf_set) r_udf <= 1'b1;
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[ST_OVF]    = r_ovf;
        w_status[ST_UDF]    = r_udf;
        w_status[ST_CLKEN]  = w_clk_en;
        w_status[ST_INFULL] = |w_in_full;
        for (int j = 0; j < NUM_OUT; j++)
            w_status[ST_OUT_NE + j] = !w_out_empty[j];
        o_host_rdata = '0;
        if (i_host_addr == ADDR_STATUS)
            o_host_rdata = w_status;
        for (int j = 0; j < NUM_OUT; j++)
            if (i_host_addr == 4'(ADDR_OUT_BASE + j))
                o_host_rdata = w_rdata[j];
    end

endmodule

// File: tb/tb_hov_stream_io.sv
// Directed bench for hov_stream_io: chunked loads, step enable, overflow,
// chunked output reads, underflow and flush, checked against hand values.
module tb_hov_stream_io;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  host_addr = '0;
    logic        host_wr = 1'b0;
    logic        host_rd = 1'b0;
    logic [5:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic [23:0] cpu_in_data;
    logic [1:0]  cpu_in_adv = '0;
    logic [11:0] cpu_out_data = '0;
    logic        cpu_out_valid = 1'b0;
    logic        cpu_out_sel = 1'b0;
    logic        cpu_clk_en;

    int nchk = 0;
    int npass = 0;

    always #5 clk = ~clk;

    hov_stream_io dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_host_addr     (host_addr),
        .i_host_wr       (host_wr),
        .i_host_rd       (host_rd),
        .i_host_wdata    (host_wdata),
        .o_host_rdata    (host_rdata),
        .o_cpu_in_data   (cpu_in_data),
        .i_cpu_in_adv    (cpu_in_adv),
        .i_cpu_out_data  (cpu_out_data),
        .i_cpu_out_valid (cpu_out_valid),
        .i_cpu_out_sel   (cpu_out_sel),
        .o_cpu_clk_en    (cpu_clk_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hwr(input logic [3:0] a, input logic [5:0] d);
        host_addr = a; host_wdata = d; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic wword(input logic [3:0] a, input logic [11:0] w);
        hwr(a, w[5:0]);
        hwr(a, w[11:6]);
    endtask

    task automatic hrd(input logic [3:0] a);
        host_addr = a; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic cpush(input logic sel, input logic [11:0] d);
        cpu_out_sel = sel; cpu_out_data = d; cpu_out_valid = 1'b1;
        tick();
        cpu_out_valid = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        check(tag, 32'(host_rdata), 32'(exp));
    endtask

    initial begin
        // Reset state
        #3;
        rchk("rst_status", 4'd15, 8'h00);
        rchk("rst_out0", 4'd8, 8'h00);
        check("rst_clken", 32'(cpu_clk_en), 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // 1: two chunks assemble 0xA85 on ch0
        hwr(4'd0, 6'h05);
        hwr(4'd0, 6'h2A);
        check("t1_ch0_head", 32'(cpu_in_data[11:0]), 32'hA85);
        rchk("t1_status", 4'd15, 8'h00);

        // 2: load ch1, step enable, consume both
        wword(4'd1, 12'hFFF);
        check("t2_ch1_head", 32'(cpu_in_data[23:12]), 32'hFFF);
        check("t2_clken_on", 32'(cpu_clk_en), 32'd1);
        rchk("t2_status", 4'd15, 8'h04);
        cpu_in_adv = 2'b11;
        tick();
        cpu_in_adv = 2'b00;
        check("t2_clken_off", 32'(cpu_clk_en), 32'd0);
        rchk("t2_status_empty", 4'd15, 8'h00);

        // 3: overflow ch0
        for (int i = 1; i <= 4; i++) wword(4'd0, 12'(i));
        rchk("t3_full", 4'd15, 8'h08);
        wword(4'd0, 12'h005);
        rchk("t3_ovf", 4'd15, 8'h09);
        check("t3_head_kept", 32'(cpu_in_data[11:0]), 32'h001);
        hwr(4'd15, 6'h01);
        rchk("t3_ovf_clr", 4'd15, 8'h08);

        // 4: CPU result through output ch1, read back in two bytes
        wword(4'd1, 12'h456);
        check("t4_ch1_head", 32'(cpu_in_data[23:12]), 32'h456);
        rchk("t4_status", 4'd15, 8'h0C);
        cpush(1'b1, 12'h123);
        rchk("t4_out1_ne", 4'd15, 8'h2C);
        rchk("t4_byte0", 4'd9, 8'h23);
        hrd(4'd9);
        rchk("t4_byte1", 4'd9, 8'h01);
        hrd(4'd9);
        rchk("t4_popped", 4'd15, 8'h0C);

        // 5: underflow on empty ch0, read counter must not move
        rchk("t5_empty_rd", 4'd8, 8'h00);
        hrd(4'd8);
        rchk("t5_udf", 4'd15, 8'h0E);
        hwr(4'd15, 6'h01);
        rchk("t5_udf_clr", 4'd15, 8'h0C);
        cpush(1'b0, 12'hABC);
        rchk("t5_no_advance", 4'd8, 8'hBC);

        // 6: fill output ch0, drain one word, flush
        cpush(1'b0, 12'h111);
        cpush(1'b0, 12'h222);
        cpush(1'b0, 12'h333);
        check("t6_clken_full", 32'(cpu_clk_en), 32'd0);
        rchk("t6_status_full", 4'd15, 8'h18);
        cpush(1'b0, 12'h777);
        hrd(4'd8);
        hrd(4'd8);
        check("t6_clken_back", 32'(cpu_clk_en), 32'd1);
        rchk("t6_next_head", 4'd8, 8'h11);
        hwr(4'd15, 6'h02);
        rchk("t6_flushed", 4'd15, 8'h00);
        check("t6_clken_flush", 32'(cpu_clk_en), 32'd0);
        wword(4'd0, 12'h9C3);
        check("t6_after_flush", 32'(cpu_in_data[11:0]), 32'h9C3);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
